// File: rtl/matrix_alu_sequencer.sv
// Command-level sequencer for the 4x4 matrix add/sub engine: load A, load B (unless reused), execute, return result.
// Optional build macro MATRIX_SEQ_TIMEOUT_EN adds err_timeout when eng_done is missing at the end of EXEC.
module matrix_alu_sequencer #(
    parameter int MEMORY_SIZE = 256,
    parameter int DATASIZE    = 16
) (
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_addsub,
    input  logic                   cmd_reuse_b,
    input  logic [MEMORY_SIZE-1:0] cmd_a,
    input  logic [MEMORY_SIZE-1:0] cmd_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [MEMORY_SIZE-1:0] res_data,
    output logic                   busy,
    inout  wire  [MEMORY_SIZE-1:0] databus,
    output logic                   eng_select,
    output logic                   eng_readwrite,
    output logic                   eng_ab_select,
    output logic                   eng_addsub,
    output logic                   eng_enable,
    input  logic                   eng_done
`ifdef MATRIX_SEQ_TIMEOUT_EN
    ,
    output logic                   err_timeout
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        RESP
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [MEMORY_SIZE-1:0] b_q;
    logic                   op_q;
    logic                   reuse_q;
    logic                   b_loaded;

    logic                   bus_drive;
    logic [MEMORY_SIZE-1:0] bus_q;

    logic                   sel_d;
    logic                   rw_d;
    logic                   ab_d;
    logic                   addsub_d;
    logic                   en_d;
    logic                   drive_d;
    logic [MEMORY_SIZE-1:0] bus_d;

    logic                   unused_cfg;
    assign unused_cfg = (DATASIZE == 0) ^ eng_done;

    // The bus is only ever driven while a write strobe is registered, so it can never fight the engine.
    assign databus = bus_drive ? bus_q : {MEMORY_SIZE{1'bz}};

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cmd_valid) next_state = LOAD_A;
            LOAD_A:  next_state = reuse_q ? EXEC : LOAD_B;
            LOAD_B:  next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (res_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Strobes are decoded from next_state and registered, so they line up exactly with the state they belong to.
    always_comb begin
        sel_d    = 1'b0;
        rw_d     = 1'b0;
        ab_d     = 1'b0;
        addsub_d = 1'b0;
        en_d     = 1'b0;
        drive_d  = 1'b0;
        bus_d    = '0;
        case (next_state)
            LOAD_A: begin
                sel_d   = 1'b1;
                rw_d    = 1'b1;
                en_d    = 1'b1;
                drive_d = 1'b1;
                bus_d   = cmd_a;
            end
            LOAD_B: begin
                sel_d   = 1'b1;
                rw_d    = 1'b1;
                ab_d    = 1'b1;
                en_d    = 1'b1;
                drive_d = 1'b1;
                bus_d   = b_q;
            end
            EXEC: begin
                sel_d    = 1'b1;
                en_d     = 1'b1;
                addsub_d = op_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            eng_select    <= 1'b0;
            eng_readwrite <= 1'b0;
            eng_ab_select <= 1'b0;
            eng_addsub    <= 1'b0;
            eng_enable    <= 1'b0;
            bus_drive     <= 1'b0;
            bus_q         <= '0;
            b_q           <= '0;
            op_q          <= 1'b0;
            reuse_q       <= 1'b0;
            b_loaded      <= 1'b0;
            res_valid     <= 1'b0;
            res_data      <= '0;
        end else begin
            cmd_ready     <= (next_state == IDLE);
            busy          <= (next_state != IDLE);
            eng_select    <= sel_d;
            eng_readwrite <= rw_d;
            eng_ab_select <= ab_d;
            eng_addsub    <= addsub_d;
            eng_enable    <= en_d;
            bus_drive     <= drive_d;
            bus_q         <= bus_d;

            if (state == IDLE && cmd_valid) begin
                b_q     <= cmd_b;
                op_q    <= cmd_addsub;
                reuse_q <= cmd_reuse_b && b_loaded;
            end

            if (state == LOAD_B) begin
                b_loaded <= 1'b1;
            end

            if (state == EXEC) begin
                res_valid <= 1'b1;
`ifdef MATRIX_SEQ_TIMEOUT_EN
                res_data  <= eng_done ? databus : '0;
`else
                res_data  <= databus;
`endif
            end else if (state == RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MATRIX_SEQ_TIMEOUT_EN
    // The timeout flag lives exactly as long as the response it qualifies.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            err_timeout <= 1'b0;
        end else if (state == EXEC) begin
            err_timeout <= !eng_done;
        end else if (state == RESP && res_ready) begin
            err_timeout <= 1'b0;
        end
    end
`endif

endmodule
